dmem_responder: RTL and testbench

- Memory-side responder for the single-cycle RV32I core's data port.
- Services the core's data address, store data, store strobe and funct3 with:
  - a byte-addressable data RAM,
  - a small MMIO region: console TX FIFO, status register, free-running cycle timer.
- Reads are combinational so the core completes loads in one cycle; all state updates on the rising clock edge.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_tx_fifo.sv | 85 ++++++++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO map, STATUS layout
// and the store-size encodings carried on funct3.
package dmem_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] TIMER_ADDR  = 32'h8000_0008;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_MIS_BIT   = 3;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } store_size_e;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Console TX byte FIFO with a registered head byte, so o_headData only
// changes on a clock edge and stays put while the consumer stalls.
module dmem_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [7:0]               i_pushData,
    input  logic                     i_pop,
    output logic [7:0]               o_headData,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic [7:0]    r_head;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_pushOk;
    logic [PW-1:0] w_rdNext;
    logic [PW:0]   w_countNext;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = i_pop && !w_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_pushOk   = i_push && (!w_full || w_pop);
    assign w_rdNext   = w_pop ? r_rdPtr + 1'b1 : r_rdPtr;

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_headData = r_head;
    assign o_overflow = i_push && w_full && !w_pop;

    always_comb begin
        w_countNext = r_count;
        case ({w_pushOk, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && w_pushOk) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // The head register must see a byte pushed into the slot that becomes head.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            r_rdPtr <= w_rdNext;
            r_count <= w_countNext;
            if (w_countNext == '0) begin
                r_head <= '0;
            end else if (w_pushOk && (r_wrPtr == w_rdNext)) begin
                r_head <= i_pushData;
            end else begin
                r_head <= r_mem[w_rdNext];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for the single-cycle RV32I core: byte-addressable RAM
// plus MMIO console FIFO, STATUS and cycle TIMER (TIMER only with DMEM_TIMER_EN).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [31:0] ram_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          r_overflow;
    logic          r_misalign;

    logic          w_isRam;
    logic [AW-1:0] w_wordIdx;
    logic [31:0]   w_ramWord;
    logic          w_sizeOk;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_laneData;
    logic          w_store;
    logic          w_misStore;
    logic          w_wrTx;
    logic          w_wrStatus;
    logic          w_wrTimer;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_fifoOverflow;
    logic [31:0]   w_status;
    logic [31:0]   w_timer;

    assign w_isRam   = !addr[31];
    assign w_wordIdx = addr[AW+1:2];
    assign w_ramWord = r_mem[w_wordIdx];

    always_comb begin
        w_sizeOk   = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_laneData = wdata;
        case (funct3)
            SIZE_BYTE: begin
                w_sizeOk   = 1'b1;
                w_be       = 4'b0001 << addr[1:0];
                w_laneData = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_sizeOk   = 1'b1;
                w_misalign = addr[0];
                w_be       = addr[1] ? 4'b1100 : 4'b0011;
                w_laneData = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                w_sizeOk   = 1'b1;
                w_misalign = |addr[1:0];
                w_be       = 4'b1111;
            end
            default: begin
                w_sizeOk = 1'b0;
            end
        endcase
    end

    assign w_store    = mem_write && w_sizeOk && !w_misalign;
    assign w_misStore = mem_write && w_sizeOk && w_misalign;
    assign w_wrTx     = w_store && (addr == TXDATA_ADDR);
    assign w_wrStatus = w_store && (addr == STATUS_ADDR);
    assign w_wrTimer  = w_store && (funct3 == SIZE_WORD) && (addr == TIMER_ADDR);

    always_ff @(posedge clock) begin
        if (!reset && w_store && w_isRam) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_wordIdx][8*i +: 8] <= w_laneData[8*i +: 8];
                end
            end
        end
    end

    assign w_pop    = tx_valid && tx_ready;
    assign tx_valid = !w_empty;

    dmem_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_txFifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_wrTx),
        .i_pushData (wdata[7:0]),
        .i_pop      (w_pop),
        .o_headData (tx_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_overflow (w_fifoOverflow)
    );

    // Setting a sticky flag takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_fifoOverflow) begin
                r_overflow <= 1'b1;
            end else if (w_wrStatus && wdata[STATUS_OVF_BIT]) begin
                r_overflow <= 1'b0;
            end
            if (w_misStore) begin
                r_misalign <= 1'b1;
            end else if (w_wrStatus && wdata[STATUS_MIS_BIT]) begin
                r_misalign <= 1'b0;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] r_timer;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_wrTimer) begin
            r_timer <= wdata;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer = r_timer;
`else
    logic w_unusedTimerWrite;

    assign w_unusedTimerWrite = w_wrTimer;
    assign w_timer            = '0;
`endif

    always_comb begin
        w_status                   = '0;
        w_status[STATUS_FULL_BIT]  = w_full;
        w_status[STATUS_EMPTY_BIT] = w_empty;
        w_status[STATUS_OVF_BIT]   = r_overflow;
        w_status[STATUS_MIS_BIT]   = r_misalign;
        w_status[7:4]              = 4'(w_count);
    end

    always_comb begin
        ram_out = '0;
        if (w_isRam) begin
            ram_out = w_ramWord >> {addr[1:0], 3'b000};
        end else begin
            case (addr)
                STATUS_ADDR: ram_out = w_status;
                TIMER_ADDR:  ram_out = w_timer;
                default:     ram_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected read data and
// TX bytes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] ram_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rdReq;

    typedef struct {
        string       name;
        logic [31:0] value;
    } readExp_t;

    readExp_t   readQ[$];
    logic [7:0] txQ[$];
    int         checkCount = 0;
    int         passCount  = 0;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .funct3    (funct3),
        .ram_out   (ram_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic we, input logic [2:0] f3);
        addr      = a;
        wdata     = d;
        mem_write = we;
        funct3    = f3;
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        rdReq     = 1'b0;
    endtask

    task automatic readCheck(input logic [31:0] a, input logic [31:0] expected,
                             input string name);
        readQ.push_back('{name: name, value: expected});
        rdReq = 1'b1;
        applyStimulus(a, 32'h0, 1'b0, SIZE_WORD);
    endtask

    task automatic pushByte(input logic [7:0] b, input bit accepted);
        if (accepted) begin
            txQ.push_back(b);
        end
        applyStimulus(TXDATA_ADDR, {24'h0, b}, 1'b1, SIZE_BYTE);
    endtask

    // Monitor: compares reads when requested and every TX handshake byte.
    always @(negedge clock) begin
        readExp_t e;
        if (rdReq) begin
            if (readQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL readQueue: got read with no expectation, expected none");
            end else begin
                e = readQ.pop_front();
                checkOutput(e.name, ram_out, e.value);
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (txQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL txPop: got byte 0x%02h, expected no byte", tx_data);
            end else begin
                checkOutput("txPop", 32'(tx_data), 32'(txQ.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        addr      = '0;
        wdata     = '0;
        mem_write = 1'b0;
        funct3    = SIZE_WORD;
        tx_ready  = 1'b0;
        rdReq     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("resetTxValid", 32'(tx_valid), 32'h0);
        checkOutput("resetTxData", 32'(tx_data), 32'h0);
        readCheck(STATUS_ADDR, 32'h02, "resetStatus");

        // Word store and shifted reads
        applyStimulus(32'h10, 32'h1122_3344, 1'b1, SIZE_WORD);
        readCheck(32'h10, 32'h1122_3344, "rdWord");
        readCheck(32'h11, 32'h0011_2233, "rdShift1");
        readCheck(32'h12, 32'h0000_1122, "rdShift2");
        readCheck(32'h13, 32'h0000_0011, "rdShift3");

        // Byte merge, misaligned half, reserved funct3, aligned upper half
        applyStimulus(32'h12, 32'h0000_00AA, 1'b1, SIZE_BYTE);
        readCheck(32'h10, 32'h11AA_3344, "sbMerge");
        applyStimulus(32'h11, 32'h0000_BEEF, 1'b1, SIZE_HALF);
        readCheck(32'h10, 32'h11AA_3344, "shMisalignRam");
        readCheck(STATUS_ADDR, 32'h0A, "misalignSet");
        applyStimulus(STATUS_ADDR, 32'h8, 1'b1, SIZE_WORD);
        readCheck(STATUS_ADDR, 32'h02, "misalignClr");
        applyStimulus(32'h10, 32'h0, 1'b1, 3'b011);
        readCheck(32'h10, 32'h11AA_3344, "reservedF3");
        readCheck(STATUS_ADDR, 32'h02, "reservedNoFlag");
        applyStimulus(32'h16, 32'h0000_5566, 1'b1, SIZE_HALF);
        readCheck(32'h16, 32'h0000_5566, "shUpper");
        readCheck(32'h1010, 32'h11AA_3344, "aliasWrap");
        readCheck(TXDATA_ADDR, 32'h0, "txdataRead");
        readCheck(32'h8000_000C, 32'h0, "unmappedRead");

        // Fill past depth with the consumer stalled
        tx_ready = 1'b0;
        for (int b = 'h41; b <= 'h45; b++) begin
            pushByte(8'(b), b <= 'h44);
        end
        checkOutput("headHeld", 32'(tx_data), 32'h41);
        checkOutput("fullValid", 32'(tx_valid), 32'h1);
        readCheck(STATUS_ADDR, 32'h45, "fullOverflow");
        checkOutput("headStable", 32'(tx_data), 32'h41);
        applyStimulus(STATUS_ADDR, 32'h4, 1'b1, SIZE_WORD);
        readCheck(STATUS_ADDR, 32'h41, "overflowClr");

        // Push and pop together while full
        tx_ready = 1'b1;
        pushByte(8'h46, 1'b1);
        tx_ready = 1'b0;
        readCheck(STATUS_ADDR, 32'h41, "fullPushPop");
        tx_ready = 1'b1;
        repeat (4) applyStimulus(32'h0, 32'h0, 1'b0, SIZE_WORD);
        tx_ready = 1'b0;
        readCheck(STATUS_ADDR, 32'h02, "drained");

        // Push into empty FIFO with consumer ready: valid only next cycle
        tx_ready  = 1'b1;
        addr      = TXDATA_ADDR;
        wdata     = 32'h55;
        funct3    = SIZE_BYTE;
        mem_write = 1'b1;
        txQ.push_back(8'h55);
        @(negedge clock);
        checkOutput("pushLatency", 32'(tx_valid), 32'h0);
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, SIZE_WORD);
        tx_ready = 1'b0;
        readCheck(STATUS_ADDR, 32'h02, "emptyAfterOne");

`ifdef DMEM_TIMER_EN
        applyStimulus(TIMER_ADDR, 32'hFFFF_FFFE, 1'b1, SIZE_WORD);
        readCheck(TIMER_ADDR, 32'hFFFF_FFFE, "timerLoad");
        readCheck(TIMER_ADDR, 32'hFFFF_FFFF, "timerInc");
        readCheck(TIMER_ADDR, 32'h0000_0000, "timerWrap");
        readCheck(TIMER_ADDR, 32'h0000_0001, "timerAfterWrap");
`else
        applyStimulus(TIMER_ADDR, 32'h0000_1234, 1'b1, SIZE_WORD);
        readCheck(TIMER_ADDR, 32'h0, "timerOff");
        readCheck(TIMER_ADDR, 32'h0, "timerOffLater");
`endif

        // Reset mid-stream with three bytes queued and a pending store
        for (int b = 'h61; b <= 'h63; b++) begin
            pushByte(8'(b), 1'b1);
        end
        applyStimulus(32'h12, 32'h0, 1'b1, SIZE_WORD);
        readCheck(STATUS_ADDR, 32'h38, "threeQueued");
        reset     = 1'b1;
        addr      = 32'h10;
        wdata     = 32'hDEAD_BEEF;
        funct3    = SIZE_WORD;
        mem_write = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_write = 1'b0;
        txQ.delete();
        checkOutput("midResetValid", 32'(tx_valid), 32'h0);
        checkOutput("midResetData", 32'(tx_data), 32'h0);
        readCheck(STATUS_ADDR, 32'h02, "midResetStatus");
        readCheck(32'h10, 32'h11AA_3344, "ramRetained");

        applyStimulus(32'h0, 32'h0, 1'b0, SIZE_WORD);
        checkOutput("txLeftover", 32'(txQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
